bht_ctrl: RTL and testbench

Branch-history controller for the 5-stage pipeline. It owns a direct-mapped table of 2-bit saturating counters indexed by PC, and initialises the table after reset with a sequenced sweep. It gates the fetch-stage taken prediction with the BTB hit, resolves mispredictions from EX-stage branch outcomes, and keeps branch and miss statistics. Its outputs drive NPC selection and the hazard unit's flush logic.

---
 rtl/bpred_pkg.sv | 21 ++
 rtl/bht_table.sv | 27 ++
 rtl/bht_ctrl.sv | 102 ++++++++++
 tb/tb_bht_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/bpred_pkg.sv
// Shared branch-predictor definitions: 2-bit counter encodings, miss codes and
// the saturating counter step used by the branch history table.
package bpred_pkg;

  localparam logic [1:0] SN = 2'b00;
  localparam logic [1:0] WN = 2'b01;
  localparam logic [1:0] WT = 2'b10;
  localparam logic [1:0] ST = 2'b11;

  localparam logic [1:0] MISS_NONE   = 2'b00;
  localparam logic [1:0] MISS_TAKEN  = 2'b10;
  localparam logic [1:0] MISS_NTAKEN = 2'b01;

  localparam logic [2:0] BR_NONE = 3'd0;

  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    if (taken) return (cnt == ST) ? ST : cnt + 2'd1;
    else       return (cnt == SN) ? SN : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/bht_table.sv
// Direct-mapped table of 2-bit saturating counters: combinational fetch read,
// one synchronous write port that either loads WN or steps the stored counter.
module bht_table #(
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_init,
  input  logic             wr_taken
);
  import bpred_pkg::*;

  logic [1:0] mem [2**IDX_W];

  // NOTE: the storage has no reset term; the controller's init sweep fills it,
  // which keeps the array mappable onto plain RAM/regfile cells.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_init ? WN : sat_update(mem[wr_idx], wr_taken);
  end

  // Read before write: a same-cycle update of this entry shows up next cycle.
  assign rd_taken = mem[rd_idx][1];

endmodule

// File: rtl/bht_ctrl.sv
// Branch-history controller: INIT sweep / RUN FSM, fetch prediction gating,
// EX-stage misprediction resolution with redirect target, and statistics.
module bht_ctrl #(
  parameter int IDX_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IFpc,
  input  logic        BTBhit,
  output logic        BHThit,
  input  logic [31:0] EXpc,
  input  logic [31:0] IDpc,
  input  logic [31:0] BrNPC,
  input  logic        BranchE,
  input  logic [2:0]  BranchTypeE,
  output logic [1:0]  PredictMiss,
  output logic [31:0] RedirectPC,
  output logic        Ready,
  output logic [31:0] BrCnt,
  output logic [31:0] MissCnt
);
  import bpred_pkg::*;

  localparam logic [0:0]       S_INIT   = 1'b0;
  localparam logic [0:0]       S_RUN    = 1'b1;
  localparam logic [IDX_W-1:0] LAST_IDX = '1;
  localparam logic [IDX_W-1:0] IDX_ONE  = 1;

  logic [0:0]       state;
  logic [IDX_W-1:0] init_idx;
  logic             run;
  logic             br_cond;
  logic [31:0]      ex_pc_plus4;
  logic [1:0]       miss_code;
  logic             rd_taken;
  logic             tbl_we;
  logic             tbl_init;
  logic [IDX_W-1:0] tbl_widx;
  logic             unused_pc_bits;

  // Reset is sampled at the edge, but all outputs must already be quiet while it is high.
  assign run         = (state == S_RUN) && !rst;
  assign br_cond     = (BranchTypeE != BR_NONE);
  assign ex_pc_plus4 = EXpc + 32'd4;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    miss_code = MISS_NONE;
    if (run) begin
      if (BranchE && (IDpc != BrNPC))                         miss_code = MISS_TAKEN;
      else if (!BranchE && br_cond && (IDpc != ex_pc_plus4)) miss_code = MISS_NTAKEN;
    end
  end

  always_comb begin
    RedirectPC = 32'd0;
    case (miss_code)
      MISS_TAKEN:  RedirectPC = BrNPC;
      MISS_NTAKEN: RedirectPC = ex_pc_plus4;
      default:     RedirectPC = 32'd0;
    endcase
  end

  assign PredictMiss = miss_code;
  assign Ready       = (state == S_RUN);
  assign BHThit      = run && BTBhit && rd_taken;

  // Write port: sweep data during INIT, counter step for resolved branches in RUN.
  assign tbl_init = (state == S_INIT);
  assign tbl_we   = !rst && (tbl_init || br_cond || BranchE);
  assign tbl_widx = tbl_init ? init_idx : EXpc[IDX_W+1:2];

  bht_table #(.IDX_W(IDX_W)) u_table (
    .clk      (clk),
    .rd_idx   (IFpc[IDX_W+1:2]),
    .rd_taken (rd_taken),
    .wr_en    (tbl_we),
    .wr_idx   (tbl_widx),
    .wr_init  (tbl_init),
    .wr_taken (BranchE)
  );

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_INIT;
      init_idx <= '0;
      BrCnt    <= 32'd0;
      MissCnt  <= 32'd0;
    end else if (state == S_INIT) begin
      init_idx <= init_idx + IDX_ONE;
      if (init_idx == LAST_IDX) state <= S_RUN;
    end else begin
      if (br_cond && (BrCnt != 32'hFFFF_FFFF))                 BrCnt   <= BrCnt + 32'd1;
      if ((miss_code != MISS_NONE) && (MissCnt != 32'hFFFF_FFFF)) MissCnt <= MissCnt + 32'd1;
    end
  end

  // Index ignores the byte offset and the high fetch-PC bits; aliasing is intended.
  assign unused_pc_bits = ^{IFpc[31:IDX_W+2], IFpc[1:0]};

endmodule

// File: tb/tb_bht_ctrl.sv
// Directed bench for bht_ctrl: expected values go into a scoreboard queue as
// stimulus is applied and are popped against DUT outputs once they settle.
module tb_bht_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] IFpc, EXpc, IDpc, BrNPC;
  logic        BTBhit, BranchE;
  logic [2:0]  BranchTypeE;
  logic        BHThit, Ready;
  logic [1:0]  PredictMiss;
  logic [31:0] RedirectPC, BrCnt, MissCnt;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  bht_ctrl #(.IDX_W(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .IFpc        (IFpc),
    .BTBhit      (BTBhit),
    .BHThit      (BHThit),
    .EXpc        (EXpc),
    .IDpc        (IDpc),
    .BrNPC       (BrNPC),
    .BranchE     (BranchE),
    .BranchTypeE (BranchTypeE),
    .PredictMiss (PredictMiss),
    .RedirectPC  (RedirectPC),
    .Ready       (Ready),
    .BrCnt       (BrCnt),
    .MissCnt     (MissCnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic push(input logic [31:0] e);
    exp_q.push_back(e);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: observed %h but scoreboard empty", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic ex_drive(input logic [31:0] ex, input logic [31:0] id, input logic [31:0] npc,
                          input logic taken, input logic [2:0] btype);
    EXpc = ex; IDpc = id; BrNPC = npc; BranchE = taken; BranchTypeE = btype;
  endtask

  initial begin
    rst = 1'b1; IFpc = 32'h0; BTBhit = 1'b0;
    ex_drive(32'h0, 32'h0, 32'h0, 1'b0, 3'd0);
    tick();

    // Reset held: outputs quiet even with a would-be miss and BTB hit.
    IFpc = 32'h100; BTBhit = 1'b1;
    ex_drive(32'h100, 32'h108, 32'h200, 1'b1, 3'd3);
    push(32'd0); push(32'd0); push(32'd0); push(32'd0);
    settle();
    check("rst_ready", Ready);
    check("rst_bhthit", BHThit);
    check("rst_miss", PredictMiss);
    check("rst_redirect", RedirectPC);

    // Sweep partially, then restart it with a reset pulse at edge 30.
    rst = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    push(32'd0); push(32'd0);
    settle();
    check("mid_sweep_ready", Ready);
    check("mid_sweep_miss", PredictMiss);
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Full sweep with EX activity that must be ignored.
    for (int i = 0; i < 64; i++) begin
      push(32'd0); push(32'd0);
      settle();
      check("init_ready", Ready);
      check("init_bhthit", BHThit);
      tick();
    end
    ex_drive(32'h0, 32'h0, 32'h0, 1'b0, 3'd0);
    BTBhit = 1'b1; IFpc = 32'h100;
    push(32'd1); push(32'd0); push(32'd0); push(32'd0);
    settle();
    check("run_ready", Ready);
    check("run_brcnt0", BrCnt);
    check("run_misscnt0", MissCnt);
    check("run_wn_bhthit", BHThit);

    // Saturation on entry of 0x100: WN -> WT -> ST -> ST -> WT -> WN.
    ex_drive(32'h100, 32'h300, 32'h300, 1'b1, 3'd1);
    push(32'd0);
    settle();
    check("sat_correct_taken_nomiss", PredictMiss);
    tick();
    push(32'd1); settle(); check("sat_wt", BHThit);
    tick();
    push(32'd1); settle(); check("sat_st", BHThit);
    tick();
    push(32'd1); settle(); check("sat_st_hold", BHThit);
    ex_drive(32'h100, 32'h104, 32'h0, 1'b0, 3'd1);
    tick();
    push(32'd1); settle(); check("sat_st_to_wt", BHThit);
    BTBhit = 1'b0;
    push(32'd0); settle(); check("btb_gate", BHThit);
    BTBhit = 1'b1;
    tick();
    push(32'd0); push(32'd5); push(32'd0);
    settle();
    check("sat_wt_to_wn", BHThit);
    check("sat_brcnt", BrCnt);
    check("sat_misscnt", MissCnt);

    // Taken miss.
    ex_drive(32'h100, 32'h108, 32'h200, 1'b1, 3'd1);
    push({30'd0, 2'b10}); push(32'h200);
    settle();
    check("tmiss_code", PredictMiss);
    check("tmiss_redirect", RedirectPC);
    tick();
    ex_drive(32'h0, 32'h0, 32'h0, 1'b0, 3'd0);
    push(32'd1); push(32'd6); push(32'd0);
    settle();
    check("tmiss_misscnt", MissCnt);
    check("tmiss_brcnt", BrCnt);
    check("idle_miss", PredictMiss);

    // Not-taken miss, then the correctly predicted fall-through.
    ex_drive(32'h100, 32'h200, 32'h0, 1'b0, 3'd3);
    push({30'd0, 2'b01}); push(32'h104);
    settle();
    check("nmiss_code", PredictMiss);
    check("nmiss_redirect", RedirectPC);
    tick();
    IDpc = 32'h104;
    push(32'd0); push(32'd0);
    settle();
    check("ncorrect_code", PredictMiss);
    check("ncorrect_redirect", RedirectPC);
    tick();
    push(32'd2); push(32'd8);
    settle();
    check("ncorrect_misscnt", MissCnt);
    check("ncorrect_brcnt", BrCnt);

    // Unconditional taken (BranchTypeE=0): updates the entry, no branch count.
    ex_drive(32'h100, 32'h500, 32'h500, 1'b1, 3'd0);
    tick();
    ex_drive(32'h0, 32'h0, 32'h0, 1'b0, 3'd0);
    tick();
    push(32'd8); push(32'd0);
    settle();
    check("uncond_brcnt", BrCnt);
    check("uncond_wn_bhthit", BHThit);

    // EXpc+4 wraps to zero.
    ex_drive(32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 3'd2);
    push(32'd0);
    settle();
    check("wrap_nomiss", PredictMiss);
    IDpc = 32'h8;
    push(32'd0);
    settle();
    check("wrap_miss_redirect", RedirectPC);
    tick();

    // Aliasing: fetch 0x100 and update 0x200 share index 0 in the same cycle.
    IFpc = 32'h100; BTBhit = 1'b1;
    ex_drive(32'h200, 32'h600, 32'h600, 1'b1, 3'd1);
    push(32'd0);
    settle();
    check("alias_old", BHThit);
    tick();
    ex_drive(32'h0, 32'h0, 32'h0, 1'b0, 3'd0);
    push(32'd1); push(32'd10); push(32'd3);
    settle();
    check("alias_new", BHThit);
    check("alias_brcnt", BrCnt);
    check("alias_misscnt", MissCnt);

    // Reset from RUN: outputs quiet immediately, stats and Ready cleared at the edge.
    rst = 1'b1;
    ex_drive(32'h100, 32'h108, 32'h200, 1'b1, 3'd1);
    push(32'd0); push(32'd0);
    settle();
    check("runrst_bhthit", BHThit);
    check("runrst_miss", PredictMiss);
    tick();
    rst = 1'b0;
    push(32'd0); push(32'd0); push(32'd0);
    settle();
    check("runrst_ready", Ready);
    check("runrst_brcnt", BrCnt);
    check("runrst_misscnt", MissCnt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
